// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: fetch PC sequencer for the pipelined RV32I core.
// Owns the PC register and arbitrates between sequential fetch, hazard stall,
// taken-branch redirect and halt drain.
//
// Ports:
//   clk          core clock, rising edge
//   reset        asynchronous active-low reset
//   stall_i      hazard-unit stall request for IF/ID
//   pc_sel_i     branch/jump taken in EX this cycle
//   br_pc_i      redirect target from EX (upper bits beyond PC_W discarded)
//   halt_i       halt opcode resolved in EX this cycle
//   pc_o         current fetch PC
//   flush_o      squash IF/ID and ID/EX at next edge (combinational)
//   halted_o     core halted, sticky until reset
//   misalign_o   sticky: a taken target had nonzero low two bits
//   branch_cnt_o saturating count of taken redirects
module pc_redirect_ctrl #(
  parameter int unsigned PC_W         = 9,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_i,
  input  logic            pc_sel_i,
  input  logic [31:0]     br_pc_i,
  input  logic            halt_i,
  output logic [PC_W-1:0] pc_o,
  output logic            flush_o,
  output logic            halted_o,
  output logic            misalign_o,
  output logic [15:0]     branch_cnt_o
);

  typedef enum logic [1:0] {StRun, StDrain, StHalted} state_e;

  localparam logic [3:0] DrainLoad = 4'(DRAIN_CYCLES - 1);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [3:0]      drain_q, drain_d;
  logic            misalign_q, misalign_d;
  logic [15:0]     br_cnt_q, br_cnt_d;
  logic [PC_W-1:0] target;

  // Target bits above the PC width are intentionally dropped.
  logic unused_br_hi;
  assign unused_br_hi = ^br_pc_i[31:PC_W];

  assign target = {br_pc_i[PC_W-1:2], 2'b00};

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    drain_d    = drain_q;
    misalign_d = misalign_q;
    br_cnt_d   = br_cnt_q;
    flush_o    = 1'b1;
    case (state_q)
      StRun: begin
        flush_o = halt_i | pc_sel_i;
        if (halt_i) begin
          drain_d = DrainLoad;
          state_d = StDrain;
        end else if (pc_sel_i) begin
          pc_d = target;
          if (br_cnt_q != 16'hFFFF) br_cnt_d = br_cnt_q + 16'd1;
          if (br_pc_i[1:0] != 2'b00) misalign_d = 1'b1;
        end else if (!stall_i) begin
          pc_d = pc_q + PC_W'(4);
        end
      end
      StDrain: begin
        if (drain_q == 4'd0) begin
          state_d = StHalted;
        end else begin
          drain_d = drain_q - 4'd1;
        end
      end
      StHalted: begin
        state_d = StHalted;
      end
      default: begin
        state_d = StRun;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StRun;
      pc_q       <= '0;
      drain_q    <= 4'd0;
      misalign_q <= 1'b0;
      br_cnt_q   <= 16'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      drain_q    <= drain_d;
      misalign_q <= misalign_d;
      br_cnt_q   <= br_cnt_d;
    end
  end

  assign pc_o         = pc_q;
  assign halted_o     = (state_q == StHalted);
  assign misalign_o   = misalign_q;
  assign branch_cnt_o = br_cnt_q;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Self-checking bench for pc_redirect_ctrl: directed vector table, hand-written
// saturation and async-reset sequences, and randomized stimulus against a
// behavioural model.
module tb_pc_redirect_ctrl;

  localparam int unsigned PC_W  = 9;
  localparam int unsigned DRAIN = 2;

  logic            clk;
  logic            reset;
  logic            stall_i;
  logic            pc_sel_i;
  logic [31:0]     br_pc_i;
  logic            halt_i;
  logic [PC_W-1:0] pc_o;
  logic            flush_o;
  logic            halted_o;
  logic            misalign_o;
  logic [15:0]     branch_cnt_o;

  pc_redirect_ctrl #(
    .PC_W         (PC_W),
    .DRAIN_CYCLES (DRAIN)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .stall_i      (stall_i),
    .pc_sel_i     (pc_sel_i),
    .br_pc_i      (br_pc_i),
    .halt_i       (halt_i),
    .pc_o         (pc_o),
    .flush_o      (flush_o),
    .halted_o     (halted_o),
    .misalign_o   (misalign_o),
    .branch_cnt_o (branch_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  typedef struct {
    logic        stall;
    logic        sel;
    logic [31:0] br;
    logic        halt;
    logic        ef;
    logic [8:0]  epc;
    logic [15:0] ecnt;
    logic        emis;
    logic        ehalt;
  } vec_t;

  vec_t vecs[21];

  // Behavioural model: PC as an integer address, halt tracked as "edges since halt".
  int unsigned m_pc;
  int unsigned m_cnt;
  bit          m_mis;
  bit          m_seen;
  int unsigned m_edges;

  function automatic bit m_halted();
    return m_seen && (m_edges >= DRAIN);
  endfunction

  task automatic m_reset();
    m_pc = 0; m_cnt = 0; m_mis = 0; m_seen = 0; m_edges = 0;
  endtask

  task automatic m_edge(input bit s, input bit sel, input logic [31:0] br, input bit h);
    if (m_seen) begin
      if (m_edges < 1000) m_edges++;
    end else if (h) begin
      m_seen  = 1;
      m_edges = 0;
    end else if (sel) begin
      m_pc = (br % 512) / 4 * 4;
      if (m_cnt < 65535) m_cnt++;
      if (br % 4 != 0) m_mis = 1;
    end else if (!s) begin
      m_pc = (m_pc + 4) % 512;
    end
  endtask

  // Called at posedge+1; returns flush sampled mid-cycle, leaves time at next posedge+1.
  task automatic cycle(input logic s, input logic sel, input logic [31:0] br, input logic h,
                       output logic fl);
    stall_i  = s;
    pc_sel_i = sel;
    br_pc_i  = br;
    halt_i   = h;
    #2;
    fl = flush_o;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    stall_i = 0; pc_sel_i = 0; br_pc_i = 0; halt_i = 0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  logic fl;

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 9'h004, 16'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 9'h008, 16'd0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 9'h00C, 16'd0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 9'h010, 16'd0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 32'h8,         1'b0, 1'b1, 9'h008, 16'd1, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 9'h008, 16'd1, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 32'h40,        1'b0, 1'b1, 9'h040, 16'd2, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 9'h040, 16'd2, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 32'h1F8,       1'b0, 1'b1, 9'h1F8, 16'd3, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 9'h1FC, 16'd3, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 9'h000, 16'd3, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 32'h0000_0206, 1'b0, 1'b1, 9'h004, 16'd4, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 9'h008, 16'd4, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 32'hABCD_E010, 1'b0, 1'b1, 9'h010, 16'd5, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 9'h014, 16'd5, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 32'h20,        1'b0, 1'b1, 9'h020, 16'd6, 1'b1, 1'b0};
    vecs[16] = '{1'b0, 1'b1, 32'h100,       1'b1, 1'b1, 9'h020, 16'd6, 1'b1, 1'b0};
    vecs[17] = '{1'b1, 1'b1, 32'h80,        1'b0, 1'b1, 9'h020, 16'd6, 1'b1, 1'b0};
    vecs[18] = '{1'b0, 1'b1, 32'h84,        1'b0, 1'b1, 9'h020, 16'd6, 1'b1, 1'b1};
    vecs[19] = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 9'h020, 16'd6, 1'b1, 1'b1};
    vecs[20] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 9'h020, 16'd6, 1'b1, 1'b1};

    // Reset values while held in reset.
    stall_i = 0; pc_sel_i = 0; br_pc_i = 0; halt_i = 0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", 32'(pc_o), 32'h0);
    chk("rst_flush", 32'(flush_o), 32'h0);
    chk("rst_halted", 32'(halted_o), 32'h0);
    chk("rst_mis", 32'(misalign_o), 32'h0);
    chk("rst_cnt", 32'(branch_cnt_o), 32'h0);
    pc_sel_i = 1'b1;
    #1;
    chk("rst_flush_sel", 32'(flush_o), 32'h1);
    pc_sel_i = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Directed vector table.
    for (int i = 0; i < 21; i++) begin
      cycle(vecs[i].stall, vecs[i].sel, vecs[i].br, vecs[i].halt, fl);
      chk($sformatf("v%0d_flush", i), 32'(fl), 32'(vecs[i].ef));
      chk($sformatf("v%0d_pc", i), 32'(pc_o), 32'(vecs[i].epc));
      chk($sformatf("v%0d_cnt", i), 32'(branch_cnt_o), 32'(vecs[i].ecnt));
      chk($sformatf("v%0d_mis", i), 32'(misalign_o), 32'(vecs[i].emis));
      chk($sformatf("v%0d_halted", i), 32'(halted_o), 32'(vecs[i].ehalt));
    end

    // Counter saturation.
    do_reset();
    for (int i = 0; i < 65534; i++) cycle(1'b0, 1'b1, 32'h0, 1'b0, fl);
    chk("sat_fffe", 32'(branch_cnt_o), 32'hFFFE);
    cycle(1'b0, 1'b1, 32'h0, 1'b0, fl);
    chk("sat_ffff_1", 32'(branch_cnt_o), 32'hFFFF);
    cycle(1'b0, 1'b1, 32'h0, 1'b0, fl);
    chk("sat_ffff_2", 32'(branch_cnt_o), 32'hFFFF);
    cycle(1'b0, 1'b1, 32'h0, 1'b0, fl);
    chk("sat_ffff_3", 32'(branch_cnt_o), 32'hFFFF);

    // Asynchronous reset mid-drain.
    do_reset();
    cycle(1'b0, 1'b0, 32'h0, 1'b0, fl);
    cycle(1'b0, 1'b1, 32'h33, 1'b0, fl);
    chk("ar_pre_pc", 32'(pc_o), 32'h30);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, fl);
    stall_i = 0; pc_sel_i = 0; br_pc_i = 0; halt_i = 0;
    #1;
    chk("ar_drain_flush", 32'(flush_o), 32'h1);
    #1;
    reset = 1'b0;
    #1;
    chk("ar_pc", 32'(pc_o), 32'h0);
    chk("ar_cnt", 32'(branch_cnt_o), 32'h0);
    chk("ar_mis", 32'(misalign_o), 32'h0);
    chk("ar_halted", 32'(halted_o), 32'h0);
    chk("ar_flush", 32'(flush_o), 32'h0);
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("ar_restart_pc", 32'(pc_o), 32'h4);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, fl);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, fl);
    chk("ar_restart_pc2", 32'(pc_o), 32'hC);
    chk("ar_restart_halted", 32'(halted_o), 32'h0);

    // Randomized run against the behavioural model.
    do_reset();
    m_reset();
    for (int i = 0; i < 3000; i++) begin
      logic        s, sel, h;
      logic [31:0] br;
      bit          exp_fl;
      s   = ($urandom_range(3) == 0);
      sel = ($urandom_range(3) == 0);
      h   = ($urandom_range(39) == 0);
      br  = $urandom;
      exp_fl = m_seen || h || sel;
      cycle(s, sel, br, h, fl);
      m_edge(s, sel, br, h);
      chk("rnd_flush", 32'(fl), 32'(exp_fl));
      chk("rnd_pc", 32'(pc_o), m_pc);
      chk("rnd_cnt", 32'(branch_cnt_o), m_cnt);
      chk("rnd_mis", 32'(misalign_o), 32'(m_mis));
      chk("rnd_halted", 32'(halted_o), 32'(m_halted()));
      if (m_seen && m_edges >= DRAIN + 3) begin
        reset = 1'b0;
        #2;
        reset = 1'b1;
        m_reset();
      end
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/pc_redirect_ctrl.md
# pc_redirect_ctrl

Sequencing controller for the fetch PC of the pipelined RV32I core. It owns the PC register, consumes the branch decision (`pc_sel_i`, `br_pc_i`) and halt detection from the EX-stage branch logic, and drives PC update, pipeline flush and halt. It arbitrates between sequential fetch, hazard-unit stall, taken-branch redirect and halt drain.

## Interface
Parameters:
- `PC_W`, 9: PC register width (byte address).
- `DRAIN_CYCLES`, 2: cycles to let MEM/WB retire after halt before `halted_o` rises; legal range 1..15.

Ports:
- `clk`  input  1  core clock; all state updates on rising edge.
- `reset`  input  1  asynchronous, active-low reset (0 = in reset).
- `stall_i`  input  1  hazard-unit stall request for IF/ID.
- `pc_sel_i`  input  1  branch/jump taken in EX this cycle.
- `br_pc_i`  input  32  redirect target from EX.
- `halt_i`  input  1  halt opcode (7'b1111111) resolved in EX this cycle.
- `pc_o`  output  PC_W  current fetch PC.
- `flush_o`  output  1  squash IF/ID and ID/EX contents at next edge.
- `halted_o`  output  1  core halted, sticky until reset.
- `misalign_o`  output  1  sticky: a taken target had `br_pc_i[1:0] != 0`.
- `branch_cnt_o`  output  16  count of taken redirects, saturating.

## Operation
- States: RUN, DRAIN, HALTED. Reset state RUN.
- RUN, priority high to low:
  - `halt_i=1`: `pc_o` holds, `flush_o=1`, drain counter loads `DRAIN_CYCLES-1`, next state DRAIN. `pc_sel_i` ignored; `branch_cnt_o` not incremented.
  - `pc_sel_i=1`: `pc_o <= br_pc_i[PC_W-1:0]` with bits [1:0] forced to 0, `flush_o=1`, `branch_cnt_o` increments unless at 16'hFFFF. If `br_pc_i[1:0] != 0`, set `misalign_o`. Redirect wins over `stall_i` (stalled instructions are squashed anyway).
  - `stall_i=1`: `pc_o` holds, `flush_o=0`.
  - Otherwise: `pc_o <= pc_o + 4`, modulo 2^PC_W (wraps to 0 from 2^PC_W-4).
- DRAIN: `pc_o` holds, `flush_o=1`, all inputs ignored; counter decrements each cycle; at counter==0 next state HALTED.
- HALTED: `pc_o` holds, `flush_o=1`, `halted_o=1`, all inputs ignored. Exit only via reset.
- `flush_o` is combinational: `(RUN & (halt_i | pc_sel_i)) | DRAIN | HALTED`. `halted_o` is decoded from the registered state only.
- Upper `br_pc_i[31:PC_W]` bits are discarded silently.

## Timing
- Reset (`reset=0`, async): `pc_o=0`, `halted_o=0`, `misalign_o=0`, `branch_cnt_o=0`, state RUN, drain counter 0. `flush_o` then evaluates to `halt_i|pc_sel_i` from the inputs. The reset is released synchronously to `clk` by the top level.
- Redirect latency: `pc_sel_i` sampled at edge N, so `pc_o` shows the target after edge N. `flush_o` is high during the cycle before edge N. There is exactly one wrong-path fetch and no bubble beyond the flush.
- Halt: `halt_i` high in cycle H. `flush_o` is high from H onward. `halted_o` rises after edge H+DRAIN_CYCLES. With the default of 2, `halted_o` rises at the third edge counting edge H.
- Back-to-back redirects in consecutive cycles are each applied and each counted.
- Reset asserted mid-DRAIN or in HALTED returns to RUN with all outputs at reset values immediately. No clock edge is needed.
- `stall_i` held indefinitely in RUN freezes `pc_o` with no side effects.

## Test plan
- Reset then 4 free-running cycles with no stall -> `pc_o` = 0, 4, 8, 12, 16; `flush_o=0` throughout.
- `stall_i=1` for 3 cycles at `pc_o=8`, with `pc_sel_i=1`, `br_pc_i=32'h40` in the middle stalled cycle -> `flush_o=1` that cycle, `pc_o=0x40` after that edge, `branch_cnt_o=1`.
- `PC_W=9`, run from `pc_o=0x1F8` -> sequence is 0x1F8, 0x1FC, 0x000. Redirect to 32'h0000_0206 -> `pc_o=0x004`, `misalign_o=1` and it stays set.
- `halt_i=1` and `pc_sel_i=1` in the same cycle at `pc_o=0x20` -> `pc_o` stays 0x20, `branch_cnt_o` is unchanged, `flush_o=1`, `halted_o=1` after 2 further edges. Later `pc_sel_i`/`stall_i` pulses have no effect.
- Preload `branch_cnt_o` to 16'hFFFE via 65534 redirects (or a forced count), then 3 more redirects -> `branch_cnt_o` reads 16'hFFFF and holds.
- `reset` pulsed low asynchronously during DRAIN, between clock edges -> outputs take reset values before the next edge. After release, fetch restarts at `pc_o=0`.
